bridge_1xn: RTL and testbench
=============================

BRIDGE_1XN -- requirements
Module: bridge_1xn

Interface
REQ-001 Parameter N_SLV, default 2: number of slave ports, legal range 1..8.
REQ-002 Parameter SLV_BASE, default {32'h1FAF_0000, 32'h0000_0000}: packed N_SLV x XLEN base addresses; slave i occupies field [i*XLEN +: XLEN].
REQ-003 Parameter SLV_MASK, default {32'hFFFF_0000, 32'hFFFF_0000}: packed N_SLV x XLEN compare masks, same field layout as SLV_BASE.
REQ-004 Parameter MISS_RDATA, default 32'h0000_0000: read data returned for unmapped reads.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 cpu_data_en  in  1  master request valid.
REQ-008 cpu_data_wen  in  4  master byte write enables.
REQ-009 cpu_data_addr  in  XLEN  master byte address.
REQ-010 cpu_data_wdata  in  XLEN  master write data.
REQ-011 cpu_data_rdata  out  XLEN  master read data, valid one cycle after the request.
REQ-012 slv_en  out  N_SLV  per-slave enable.
REQ-013 slv_wen  out  4*N_SLV  per-slave byte write enables.
REQ-014 slv_addr / slv_wdata  out  XLEN*N_SLV each  per-slave address and write data.
REQ-015 slv_rdata  in  XLEN*N_SLV  per-slave read data, one-cycle latency.
REQ-016 err_clr  in  1  clears the error capture state.
REQ-017 err_valid / err_addr / err_cnt  out  1 / XLEN / 16  sticky miss flag, first-miss address, saturating miss count.

Function
REQ-018 Hit for slave i: (cpu_data_addr & mask_i) == (base_i & mask_i); decode is combinational.
REQ-019 Multiple hits: the lowest index wins, and only one slv_en bit is ever asserted.
REQ-020 slv_en[i] = cpu_data_en & win_i; slv_wen for slave i = win_i ? cpu_data_wen : 0.
REQ-021 slv_addr and slv_wdata broadcast the unmodified master values to every slave.
REQ-022 Miss: no slv_en asserted; writes are dropped silently.
REQ-023 Read-select register sel_q (one-hot N_SLV plus miss bit) loads on every cycle with cpu_data_en=1 and holds otherwise.
REQ-024 cpu_data_rdata = slv_rdata of the slave selected by sel_q; MISS_RDATA when sel_q is miss.
REQ-025 Back-to-back requests to different slaves in consecutive cycles each return the correct slave's data, with no bubble.
REQ-026 Read-after-write latency is identical to read latency: one cycle, and rdata after a write is don't-care.

Reset
REQ-027 While reset=0: sel_q points to slave 0, err_valid=0, err_addr=0, err_cnt=0.
REQ-028 During reset, slave outputs remain combinational; the master holds cpu_data_en=0.
REQ-029 Reset asserted mid-transaction: the pending read data is discarded, and the first post-reset response comes from slave 0's rdata.

Configuration
REQ-030 Macro BRIDGE_ERR_CAPTURE_EN defined, on a miss with cpu_data_en=1:
- err_cnt increments, saturating at 16'hFFFF.
- err_addr captures the address only when err_valid=0.
- err_valid sets.
REQ-031 err_clr: err_clr=1 zeroes all three error outputs next cycle; a miss in the same cycle wins (err_valid=1, err_addr=new address, err_cnt=1).
REQ-032 Macro BRIDGE_ERR_CAPTURE_EN undefined: the ports remain, err_* outputs are tied to 0, and err_clr is ignored.

Structure
REQ-033 cpu.vh holds XLEN, the confreg base/mask constants and the MISS_RDATA default.
REQ-034 One sub-module, addr_decode: pure combinational priority decoder producing the one-hot window and the miss bit.

Verification
REQ-035 N_SLV=2, read at 32'h1FAF_F000 (sram rdata 32'h1111_1111, conf rdata 32'h2222_2222) -> slv_en=2'b10, rdata=32'h2222_2222 next cycle.
REQ-036 Reads alternating 32'h0000_0010 and 32'h1FAF_0004 on consecutive cycles -> each cycle returns the correct slave's data.
REQ-037 Overlapping windows, slave 0 mask 0 -> all addresses select slave 0.
REQ-038 Write to 32'h8000_0000 with no window matching -> slv_en=0, rdata=MISS_RDATA; with the macro defined: err_valid=1, err_addr=32'h8000_0000, err_cnt=1.
REQ-039 Second miss at 32'h9000_0000 together with err_clr=1 -> err_addr=32'h9000_0000, err_cnt=1; 65540 misses -> err_cnt=16'hFFFF.
REQ-040 reset=0 pulsed between a read request and its response -> err_* = 0 and sel_q returns to slave 0.

Source files
------------

// File: rtl/bridge_1xn_pkg.sv
// Shared constants and helpers for the 1-to-N CPU data bridge.
// Holds XLEN, the confreg/sram windows and the unmapped-read default.
package bridge_1xn_pkg;

   localparam int XLEN = 32;
   localparam int ERR_CNT_W = 16;

   localparam logic [XLEN-1:0] SRAM_BASE = 32'h0000_0000;
   localparam logic [XLEN-1:0] SRAM_MASK = 32'hFFFF_0000;
   localparam logic [XLEN-1:0] CONF_BASE = 32'h1FAF_0000;
   localparam logic [XLEN-1:0] CONF_MASK = 32'hFFFF_0000;

   localparam logic [XLEN-1:0] MISS_RDATA_DEF = 32'h0000_0000;

   function automatic logic win_hit(
      input logic [XLEN-1:0] addr,
      input logic [XLEN-1:0] base,
      input logic [XLEN-1:0] mask
   );
      return (addr & mask) == (base & mask);
   endfunction

endpackage

// File: rtl/bridge_1xn_if.sv
// CPU data bus between the core and the bridge.
// The master drives the request; the bridge answers with read data.
interface bridge_1xn_if;
   import bridge_1xn_pkg::*;

   logic            cpu_data_en;
   logic [3:0]      cpu_data_wen;
   logic [XLEN-1:0] cpu_data_addr;
   logic [XLEN-1:0] cpu_data_wdata;
   logic [XLEN-1:0] cpu_data_rdata;

   modport master (
      output cpu_data_en,
      output cpu_data_wen,
      output cpu_data_addr,
      output cpu_data_wdata,
      input  cpu_data_rdata
   );

   modport slave (
      input  cpu_data_en,
      input  cpu_data_wen,
      input  cpu_data_addr,
      input  cpu_data_wdata,
      output cpu_data_rdata
   );

endinterface

// File: rtl/bridge_1xn_addr_decode.sv
// Combinational priority address decoder for the bridge.
// Produces a one-hot window (lowest index wins) and a miss flag.
module addr_decode
   import bridge_1xn_pkg::*;
#(
   parameter int                     N_SLV    = 2,
   parameter logic [N_SLV*XLEN-1:0]  SLV_BASE = {CONF_BASE, SRAM_BASE},
   parameter logic [N_SLV*XLEN-1:0]  SLV_MASK = {CONF_MASK, SRAM_MASK}
) (
   input  logic [XLEN-1:0]  addr,
   output logic [N_SLV-1:0] win,
   output logic             miss
);

   // scan high to low so the lowest matching index is the last to claim
   always_comb begin
      win  = '0;
      miss = 1'b1;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if (win_hit(addr, SLV_BASE[i*XLEN +: XLEN],
                     SLV_MASK[i*XLEN +: XLEN])) begin
            win    = '0;
            win[i] = 1'b1;
            miss   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/bridge_1xn.sv
// 1-to-N CPU data bridge with one-cycle read return and miss capture.
// Optional miss capture is built when BRIDGE_ERR_CAPTURE_EN is defined.
module bridge_1xn
   import bridge_1xn_pkg::*;
#(
   parameter int                     N_SLV      = 2,
   parameter logic [N_SLV*XLEN-1:0]  SLV_BASE   = {CONF_BASE, SRAM_BASE},
   parameter logic [N_SLV*XLEN-1:0]  SLV_MASK   = {CONF_MASK, SRAM_MASK},
   parameter logic [XLEN-1:0]        MISS_RDATA = MISS_RDATA_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   bridge_1xn_if.slave             cpu,
   output logic [N_SLV-1:0]        slv_en,
   output logic [4*N_SLV-1:0]      slv_wen,
   output logic [XLEN*N_SLV-1:0]   slv_addr,
   output logic [XLEN*N_SLV-1:0]   slv_wdata,
   input  logic [XLEN*N_SLV-1:0]   slv_rdata,
   input  logic                    err_clr,
   output logic                    err_valid,
   output logic [XLEN-1:0]         err_addr,
   output logic [ERR_CNT_W-1:0]    err_cnt
);

   localparam int SEL_W = N_SLV + 1;

   logic [N_SLV-1:0] win;
   logic             miss;
   logic [SEL_W-1:0] sel_q;

   addr_decode #(
      .N_SLV    (N_SLV),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .addr (cpu.cpu_data_addr),
      .win  (win),
      .miss (miss)
   );

   assign slv_addr  = {N_SLV{cpu.cpu_data_addr}};
   assign slv_wdata = {N_SLV{cpu.cpu_data_wdata}};

   // route enable and byte enables to the single winning slave
   always_comb begin
      slv_en  = '0;
      slv_wen = '0;
      for (int i = 0; i < N_SLV; i++) begin
         slv_en[i]        = cpu.cpu_data_en & win[i];
         slv_wen[i*4 +: 4] = win[i] ? cpu.cpu_data_wen : 4'h0;
      end
   end

   // remember which slave answers next cycle; miss is the top bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         sel_q <= SEL_W'(1);
      else if (cpu.cpu_data_en)
         sel_q <= {miss, win};
   end

   // return the selected slave's data, or the miss pattern
   always_comb begin
      cpu.cpu_data_rdata = MISS_RDATA;
      if (!sel_q[N_SLV]) begin
         for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i])
               cpu.cpu_data_rdata = slv_rdata[i*XLEN +: XLEN];
         end
      end
   end

`ifdef BRIDGE_ERR_CAPTURE_EN
   logic miss_hit;
   assign miss_hit = cpu.cpu_data_en & miss;

   // sticky miss capture; a fresh miss outranks a same-cycle clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_valid <= 1'b0;
         err_addr  <= '0;
         err_cnt   <= '0;
      end else if (miss_hit) begin
         err_valid <= 1'b1;
         if (err_clr || !err_valid)
            err_addr <= cpu.cpu_data_addr;
         if (err_clr)
            err_cnt <= ERR_CNT_W'(1);
         else if (err_cnt != {ERR_CNT_W{1'b1}})
            err_cnt <= err_cnt + ERR_CNT_W'(1);
      end else if (err_clr) begin
         err_valid <= 1'b0;
         err_addr  <= '0;
         err_cnt   <= '0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_valid = 1'b0;
   assign err_addr  = '0;
   assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_bridge_1xn.sv
// Directed self-checking bench for bridge_1xn.
// Error checks follow BRIDGE_ERR_CAPTURE_EN when it is defined.
module tb_bridge_1xn;
   import bridge_1xn_pkg::*;

   localparam logic [31:0] MISS_PAT = 32'hDEAD_BEEF;
   localparam logic [31:0] RD0 = 32'h1111_1111;
   localparam logic [31:0] RD1 = 32'h2222_2222;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bridge_1xn_if ia ();
   bridge_1xn_if ib ();

   logic [1:0]  a_en, b_en;
   logic [7:0]  a_wen, b_wen;
   logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
   logic [63:0] rd;
   logic        a_clr, b_clr;
   logic        a_ev, b_ev;
   logic [31:0] a_ea, b_ea;
   logic [15:0] a_ec, b_ec;

   assign rd = {RD1, RD0};

   bridge_1xn #(
      .N_SLV      (2),
      .MISS_RDATA (MISS_PAT)
   ) u_a (
      .clk       (clk),
      .reset     (reset),
      .cpu       (ia.slave),
      .slv_en    (a_en),
      .slv_wen   (a_wen),
      .slv_addr  (a_addr),
      .slv_wdata (a_wdata),
      .slv_rdata (rd),
      .err_clr   (a_clr),
      .err_valid (a_ev),
      .err_addr  (a_ea),
      .err_cnt   (a_ec)
   );

   bridge_1xn #(
      .N_SLV    (2),
      .SLV_MASK ({32'hFFFF_0000, 32'h0000_0000})
   ) u_b (
      .clk       (clk),
      .reset     (reset),
      .cpu       (ib.slave),
      .slv_en    (b_en),
      .slv_wen   (b_wen),
      .slv_addr  (b_addr),
      .slv_wdata (b_wdata),
      .slv_rdata (rd),
      .err_clr   (b_clr),
      .err_valid (b_ev),
      .err_addr  (b_ea),
      .err_cnt   (b_ec)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic req(input logic en, input logic [3:0] wen,
                      input logic [31:0] addr);
      ia.cpu_data_en    = en;
      ia.cpu_data_wen   = wen;
      ia.cpu_data_addr  = addr;
      ia.cpu_data_wdata = ~addr;
   endtask

   task automatic err_chk(input string tag, input logic v,
                          input logic [31:0] a, input logic [15:0] c);
`ifdef BRIDGE_ERR_CAPTURE_EN
      chk({tag, "_valid"}, 64'(a_ev), 64'(v));
      chk({tag, "_addr"}, 64'(a_ea), 64'(a));
      chk({tag, "_cnt"}, 64'(a_ec), 64'(c));
`else
      if (v || a != 0 || c != 0) begin end
      chk({tag, "_valid"}, 64'(a_ev), 64'd0);
      chk({tag, "_addr"}, 64'(a_ea), 64'd0);
      chk({tag, "_cnt"}, 64'(a_ec), 64'd0);
`endif
   endtask

   logic [31:0] alt_addr [4];
   logic [31:0] alt_exp  [4];

   initial begin
      alt_addr = '{32'h0000_0010, 32'h1FAF_0004,
                   32'h0000_0010, 32'h1FAF_0004};
      alt_exp  = '{RD0, RD1, RD0, RD1};

      reset = 1'b0;
      a_clr = 1'b0;
      b_clr = 1'b0;
      req(1'b0, 4'h0, 32'h0);
      ib.cpu_data_en    = 1'b0;
      ib.cpu_data_wen   = 4'h0;
      ib.cpu_data_addr  = 32'h0;
      ib.cpu_data_wdata = 32'h0;

      repeat (3) @(negedge clk);
      chk("rst_rdata", 64'(ia.cpu_data_rdata), 64'(RD0));
      err_chk("rst", 1'b0, 32'h0, 16'h0);
      reset = 1'b1;

      // conf read
      @(negedge clk);
      req(1'b1, 4'h0, 32'h1FAF_F000);
      #1;
      chk("conf_en", 64'(a_en), 64'h2);
      chk("conf_wen", 64'(a_wen), 64'h0);
      chk("bcast_addr", a_addr, {2{32'h1FAF_F000}});
      chk("bcast_wdata", a_wdata, {2{~32'h1FAF_F000}});
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0);
      chk("conf_rdata", 64'(ia.cpu_data_rdata), 64'(RD1));

      // writes: byte enables follow the winner
      @(negedge clk);
      req(1'b1, 4'h5, 32'h0000_0020);
      #1;
      chk("wr_sram_en", 64'(a_en), 64'h1);
      chk("wr_sram_wen", 64'(a_wen), 64'h05);
      req(1'b1, 4'hA, 32'h1FAF_0008);
      #1;
      chk("wr_conf_wen", 64'(a_wen), 64'hA0);

      // back-to-back alternating reads
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k > 0)
            chk($sformatf("alt_%0d", k - 1),
                64'(ia.cpu_data_rdata), 64'(alt_exp[k-1]));
         req(1'b1, 4'h0, alt_addr[k]);
      end
      @(negedge clk);
      chk("alt_3", 64'(ia.cpu_data_rdata), 64'(alt_exp[3]));
      req(1'b0, 4'h0, 32'h0);

      // idle holds sel
      @(negedge clk);
      chk("hold_rdata", 64'(ia.cpu_data_rdata), 64'(RD1));

      // overlapping windows on u_b
      ib.cpu_data_en   = 1'b1;
      ib.cpu_data_addr = 32'h1FAF_0004;
      #1;
      chk("ovl_conf_en", 64'(b_en), 64'h1);
      @(negedge clk);
      chk("ovl_rdata", 64'(ib.cpu_data_rdata), 64'(RD0));
      ib.cpu_data_addr = 32'h8000_0000;
      #1;
      chk("ovl_hi_en", 64'(b_en), 64'h1);
      @(negedge clk);
      ib.cpu_data_en = 1'b0;
      chk("ovl_hi_rdata", 64'(ib.cpu_data_rdata), 64'(RD0));
      chk("ovl_no_err", 64'(b_ev), 64'h0);

      // unmapped write
      req(1'b1, 4'hF, 32'h8000_0000);
      #1;
      chk("miss_en", 64'(a_en), 64'h0);
      chk("miss_wen", 64'(a_wen), 64'h0);
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0);
      chk("miss_rdata", 64'(ia.cpu_data_rdata), 64'(MISS_PAT));
      err_chk("miss1", 1'b1, 32'h8000_0000, 16'd1);

      // second miss with clear: miss wins
      req(1'b1, 4'h0, 32'h9000_0000);
      a_clr = 1'b1;
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0);
      a_clr = 1'b0;
      err_chk("miss_clr", 1'b1, 32'h9000_0000, 16'd1);

      // further miss keeps first address
      req(1'b1, 4'h0, 32'hA000_0000);
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0);
      err_chk("sticky", 1'b1, 32'h9000_0000, 16'd2);

      // plain clear
      a_clr = 1'b1;
      @(negedge clk);
      a_clr = 1'b0;
      err_chk("clr", 1'b0, 32'h0, 16'd0);

      // saturation
      req(1'b1, 4'h0, 32'hC000_0000);
      for (int k = 0; k < 65540; k++)
         @(negedge clk);
      req(1'b0, 4'h0, 32'h0);
      err_chk("sat", 1'b1, 32'hC000_0000, 16'hFFFF);

      // reset between request and response
      req(1'b1, 4'h0, 32'h1FAF_0000);
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0);
      reset = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_rdata", 64'(ia.cpu_data_rdata), 64'(RD0));
      err_chk("rst_mid", 1'b0, 32'h0, 16'h0);
      @(negedge clk);
      chk("rst_post_rdata", 64'(ia.cpu_data_rdata), 64'(RD0));

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
